// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, Status/Cause field positions,
// packed field structs and helpers that expand them to architectural words.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_EBASE    = 5'd15;
  localparam logic [2:0] SEL_PRID     = 3'd0;
  localparam logic [2:0] SEL_EBASE    = 3'd1;

  localparam int SR_BEV    = 22;
  localparam int SR_IM     = 8;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;
  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_TI  = 30;
  localparam int CAUSE_IV  = 23;
  localparam int CAUSE_IP  = 8;
  localparam int CAUSE_EXC = 2;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       iv;
    logic [7:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] status_word(status_t s);
    logic [31:0] w;
    w             = '0;
    w[SR_BEV]     = s.bev;
    w[SR_IM +: 8] = s.im;
    w[SR_EXL]     = s.exl;
    w[SR_IE]      = s.ie;
    return w;
  endfunction

  // TI lives in the timer, so it is merged in at read time.
  function automatic logic [31:0] cause_word(cause_t c, logic ti);
    logic [31:0] w;
    w                 = '0;
    w[CAUSE_BD]       = c.bd;
    w[CAUSE_TI]       = ti;
    w[CAUSE_IV]       = c.iv;
    w[CAUSE_IP +: 8]  = c.ip;
    w[CAUSE_EXC +: 5] = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 access bundle: MTC0/MFC0 from the pipeline, commit strobes from the
// exception unit, and the status the exception unit consumes.
interface cp0_regfile_if;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [2:0]  mfc0_sel;
  logic [31:0] mfc0_rdata;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        exc_badvaddr_we;
  logic [31:0] exc_badvaddr;
  logic        exc_clear_exl;
  logic [5:0]  ext_int;
  logic        status_bev;
  logic        status_exl;
  logic        cause_iv;
  logic [31:0] ebase;
  logic [31:0] epc;
  logic        allow_int;
  logic [7:0]  int_flag;
  logic        timer_int;

  modport master (
    output mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata, mfc0_addr, mfc0_sel,
           exc_we, exc_code, exc_epc, exc_bd, exc_badvaddr_we, exc_badvaddr,
           exc_clear_exl, ext_int,
    input  mfc0_rdata, status_bev, status_exl, cause_iv, ebase, epc,
           allow_int, int_flag, timer_int
  );

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata, mfc0_addr, mfc0_sel,
           exc_we, exc_code, exc_epc, exc_bd, exc_badvaddr_we, exc_badvaddr,
           exc_clear_exl, ext_int,
    output mfc0_rdata, status_bev, status_exl, cause_iv, ebase, epc,
           allow_int, int_flag, timer_int
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI is sticky until
// Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic half;

  // Half-rate count; a Count load restarts the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      half  <= 1'b0;
      count <= '0;
    end else if (count_we) begin
      half  <= 1'b0;
      count <= wdata;
    end else begin
      half  <= ~half;
      if (half) count <= count + 32'd1;
    end
  end

  // Compare holds the match value.
  always_ff @(posedge clk) begin
    if (reset)           compare <= '0;
    else if (compare_we) compare <= wdata;
  end

  // Sticky match flag on pre-increment values; a Compare write clears it first.
  always_ff @(posedge clk) begin
    if (reset)                                     ti <= 1'b0;
    else if (compare_we)                           ti <= 1'b0;
    else if (count == compare && compare != '0)    ti <= 1'b1;
  end
endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, EBase, PRId and, when
// CP0_TIMER_INT_EN is defined, Count/Compare with the timer interrupt.
// Exception commits beat MTC0 on EXL, EPC, BD and ExcCode.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID        = 32'h00004220,
  parameter logic [31:0] EBASE_RESET = 32'h80000000
) (
  input logic         clk,
  input logic         reset,
  cp0_regfile_if.slave bus
);
  status_t     status_q;
  cause_t      cause_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [17:0] ebase_q;
  logic [31:0] ebase_w;
  logic        ti;

  logic wr_status, wr_cause, wr_epc, wr_ebase;
  assign wr_status = bus.mtc0_we && bus.mtc0_sel == 3'd0 && bus.mtc0_addr == CP0_STATUS;
  assign wr_cause  = bus.mtc0_we && bus.mtc0_sel == 3'd0 && bus.mtc0_addr == CP0_CAUSE;
  assign wr_epc    = bus.mtc0_we && bus.mtc0_sel == 3'd0 && bus.mtc0_addr == CP0_EPC;
  assign wr_ebase  = bus.mtc0_we && bus.mtc0_sel == SEL_EBASE && bus.mtc0_addr == CP0_EBASE;

`ifdef CP0_TIMER_INT_EN
  logic        wr_count, wr_compare;
  logic [31:0] count, compare;
  assign wr_count   = bus.mtc0_we && bus.mtc0_sel == 3'd0 && bus.mtc0_addr == CP0_COUNT;
  assign wr_compare = bus.mtc0_we && bus.mtc0_sel == 3'd0 && bus.mtc0_addr == CP0_COMPARE;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // Status: software fields from MTC0, EXL owned by exception/ERET when active.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '{bev: 1'b1, im: 8'h00, exl: 1'b0, ie: 1'b0};
    end else begin
      if (wr_status) begin
        status_q.bev <= bus.mtc0_wdata[SR_BEV];
        status_q.im  <= bus.mtc0_wdata[SR_IM +: 8];
        status_q.ie  <= bus.mtc0_wdata[SR_IE];
      end
      if (bus.exc_we)             status_q.exl <= 1'b1;
      else if (bus.exc_clear_exl) status_q.exl <= 1'b0;
      else if (wr_status)         status_q.exl <= bus.mtc0_wdata[SR_EXL];
    end
  end

  // Cause: IV/IP[1:0] from software, IP[7:2] resampled each cycle, BD/ExcCode on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= '0;
    end else begin
      cause_q.ip[7:2] <= {bus.ext_int[5] | ti, bus.ext_int[4:0]};
      if (wr_cause) begin
        cause_q.iv      <= bus.mtc0_wdata[CAUSE_IV];
        cause_q.ip[1:0] <= bus.mtc0_wdata[CAUSE_IP +: 2];
      end
      if (bus.exc_we) begin
        cause_q.exc_code <= bus.exc_code;
        if (!status_q.exl) cause_q.bd <= bus.exc_bd;
      end
    end
  end

  // EPC/BadVAddr/EBase; a nested exception (EXL set) keeps the original EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q      <= '0;
      badvaddr_q <= '0;
      ebase_q    <= EBASE_RESET[29:12];
    end else begin
      if (bus.exc_we) begin
        if (!status_q.exl) epc_q <= bus.exc_epc;
      end else if (wr_epc) begin
        epc_q <= bus.mtc0_wdata;
      end
      if (bus.exc_badvaddr_we) badvaddr_q <= bus.exc_badvaddr;
      if (wr_ebase)            ebase_q    <= bus.mtc0_wdata[29:12];
    end
  end

  assign ebase_w = {EBASE_RESET[31:30], ebase_q, 12'h000};

  // MFC0 read mux on current state; unmapped selects read 0.
  always_comb begin
    bus.mfc0_rdata = '0;
    if (bus.mfc0_sel == 3'd0) begin
      case (bus.mfc0_addr)
        CP0_BADVADDR: bus.mfc0_rdata = badvaddr_q;
`ifdef CP0_TIMER_INT_EN
        CP0_COUNT:    bus.mfc0_rdata = count;
        CP0_COMPARE:  bus.mfc0_rdata = compare;
`endif
        CP0_STATUS:   bus.mfc0_rdata = status_word(status_q);
        CP0_CAUSE:    bus.mfc0_rdata = cause_word(cause_q, ti);
        CP0_EPC:      bus.mfc0_rdata = epc_q;
        CP0_PRID:     bus.mfc0_rdata = PRID;
        default:      bus.mfc0_rdata = '0;
      endcase
    end else if (bus.mfc0_sel == SEL_EBASE && bus.mfc0_addr == CP0_EBASE) begin
      bus.mfc0_rdata = ebase_w;
    end
  end

  assign bus.status_bev = status_q.bev;
  assign bus.status_exl = status_q.exl;
  assign bus.cause_iv   = cause_q.iv;
  assign bus.ebase      = ebase_w;
  assign bus.epc        = epc_q;
  assign bus.allow_int  = status_q.ie & ~status_q.exl;
  assign bus.int_flag   = cause_q.ip & status_q.im;
  assign bus.timer_int  = ti;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile; expected values queue up as stimulus is
// driven and are popped in order when the DUT is sampled.
module tb_cp0_regfile;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cp0_regfile_if bus();

  cp0_regfile #(.PRID(32'h00004220), .EBASE_RESET(32'h80000000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  task automatic exp_push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: got %h required none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Combinational read sampled mid low-phase, then realign to the next negedge.
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] val);
    logic [31:0] d;
    exp_push(tag, val);
    bus.mfc0_addr = a;
    bus.mfc0_sel  = s;
    #1;
    d = bus.mfc0_rdata;
    got(d);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = a;
    bus.mtc0_sel   = s;
    bus.mtc0_wdata = d;
    @(negedge clk);
    bus.mtc0_we    = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    bus.exc_we   = 1'b1;
    bus.exc_code = code;
    bus.exc_epc  = pc;
    bus.exc_bd   = bd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset = 1'b1;
    bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_sel = 0; bus.mtc0_wdata = 0;
    bus.mfc0_addr = 0; bus.mfc0_sel = 0;
    bus.exc_we = 0; bus.exc_code = 0; bus.exc_epc = 0; bus.exc_bd = 0;
    bus.exc_badvaddr_we = 0; bus.exc_badvaddr = 0; bus.exc_clear_exl = 0;
    bus.ext_int = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    exp_push("rst_bev", 32'd1);
    exp_push("rst_allow", 32'd0);
    exp_push("rst_int_flag", 32'd0);
    exp_push("rst_timer_int", 32'd0);
    exp_push("rst_ebase_out", 32'h80000000);
    got(bus.status_bev); got(bus.allow_int); got(bus.int_flag);
    got(bus.timer_int); got(bus.ebase);
    rd_chk("rst_status", CP0_STATUS, 3'd0, 32'h00400000);
    rd_chk("rst_ebase", CP0_EBASE, SEL_EBASE, 32'h80000000);
    rd_chk("rst_prid", CP0_PRID, SEL_PRID, 32'h00004220);
    rd_chk("rst_cause", CP0_CAUSE, 3'd0, 32'h0);
    rd_chk("rst_epc", CP0_EPC, 3'd0, 32'h0);

    // interrupt mask and a one-cycle ext_int pulse
    mtc0(CP0_STATUS, 3'd0, 32'h0000FF01);
    rd_chk("status_im", CP0_STATUS, 3'd0, 32'h0000FF01);
    bus.ext_int = 6'b000001;
    exp_push("int_flag_ip2", 32'h04);
    exp_push("allow_int_on", 32'd1);
    @(negedge clk);
    bus.ext_int = 6'b0;
    got(bus.int_flag); got(bus.allow_int);
    exp_push("int_flag_drop", 32'h00);
    @(negedge clk);
    got(bus.int_flag);

    // first exception records EPC and sets EXL
    exc(5'h00, 32'hBFC00100, 1'b0);
    exp_push("exc1_exl", 32'd1);
    exp_push("exc1_allow", 32'd0);
    exp_push("exc1_epc", 32'hBFC00100);
    @(negedge clk);
    bus.exc_we = 0;
    got(bus.status_exl); got(bus.allow_int); got(bus.epc);
    rd_chk("exc1_status", CP0_STATUS, 3'd0, 32'h0000FF03);

    // nested exception keeps EPC and BD, updates ExcCode
    exc(5'h02, 32'h12345678, 1'b1);
    exp_push("exc2_epc_kept", 32'hBFC00100);
    @(negedge clk);
    bus.exc_we = 0;
    got(bus.epc);
    rd_chk("exc2_cause", CP0_CAUSE, 3'd0, 32'h00000008);

    // ERET
    bus.exc_clear_exl = 1'b1;
    exp_push("eret_exl", 32'd0);
    exp_push("eret_allow", 32'd1);
    @(negedge clk);
    bus.exc_clear_exl = 0;
    got(bus.status_exl); got(bus.allow_int);

    // exception + ERET + MTC0 EPC + BadVAddr in one cycle: exception wins
    exc(5'h04, 32'h80001000, 1'b1);
    bus.exc_clear_exl   = 1'b1;
    bus.exc_badvaddr_we = 1'b1;
    bus.exc_badvaddr    = 32'h00000003;
    exp_push("mix_exl", 32'd1);
    exp_push("mix_epc", 32'h80001000);
    mtc0(CP0_EPC, 3'd0, 32'hDEAD0000);
    bus.exc_we = 0; bus.exc_clear_exl = 0; bus.exc_badvaddr_we = 0;
    got(bus.status_exl); got(bus.epc);
    rd_chk("mix_badvaddr", CP0_BADVADDR, 3'd0, 32'h00000003);
    rd_chk("mix_cause", CP0_CAUSE, 3'd0, 32'h80000010);

    // ERET, then exception with MTC0 Status: MTC0 keeps non-EXL fields
    bus.exc_clear_exl = 1'b1;
    @(negedge clk);
    bus.exc_clear_exl = 0;
    exc(5'h01, 32'h00000040, 1'b0);
    exp_push("exc_st_bev", 32'd0);
    exp_push("exc_st_epc", 32'h00000040);
    mtc0(CP0_STATUS, 3'd0, 32'h00000000);
    bus.exc_we = 0;
    got(bus.status_bev); got(bus.epc);
    rd_chk("exc_st_status", CP0_STATUS, 3'd0, 32'h00000002);
    bus.exc_clear_exl = 1'b1;
    @(negedge clk);
    bus.exc_clear_exl = 0;
    mtc0(CP0_STATUS, 3'd0, 32'h0000FF01);

    // plain MTC0 writes and field masking
    mtc0(CP0_EPC, 3'd0, 32'hDEAD0000);
    rd_chk("mtc0_epc", CP0_EPC, 3'd0, 32'hDEAD0000);
    mtc0(CP0_CAUSE, 3'd0, 32'hFFFFFFFF);
    exp_push("cause_iv", 32'd1);
    exp_push("int_flag_sw", 32'h03);
    got(bus.cause_iv); got(bus.int_flag);
    rd_chk("cause_mask", CP0_CAUSE, 3'd0, 32'h00800304);
    mtc0(CP0_EBASE, SEL_EBASE, 32'hFFFFFFFF);
    exp_push("ebase_out", 32'hBFFFF000);
    got(bus.ebase);
    rd_chk("ebase_mask", CP0_EBASE, SEL_EBASE, 32'hBFFFF000);
    mtc0(CP0_BADVADDR, 3'd0, 32'h0000FFFF);
    rd_chk("badvaddr_ro", CP0_BADVADDR, 3'd0, 32'h00000003);
    mtc0(CP0_PRID, SEL_PRID, 32'h0);
    rd_chk("prid_ro", CP0_PRID, SEL_PRID, 32'h00004220);
    rd_chk("unmapped_reg", 5'd3, 3'd0, 32'h0);
    rd_chk("unmapped_sel", CP0_STATUS, 3'd2, 32'h0);

`ifdef CP0_TIMER_INT_EN
    // Count loaded at edge 0, Compare at edge 1; Count==10 after edge 20, TI after edge 21
    mtc0(CP0_COUNT, 3'd0, 32'd0);
    mtc0(CP0_COMPARE, 3'd0, 32'd10);
    repeat (19) @(negedge clk);
    exp_push("ti_before", 32'd0);
    got(bus.timer_int);
    @(negedge clk);
    exp_push("ti_set", 32'd1);
    got(bus.timer_int);
    @(negedge clk);
    exp_push("int_flag_ip7", 32'd1);
    got(bus.int_flag[7]);
    repeat (5) @(negedge clk);
    exp_push("ti_sticky", 32'd1);
    got(bus.timer_int);
    mtc0(CP0_COMPARE, 3'd0, 32'd0);
    exp_push("ti_clear", 32'd0);
    got(bus.timer_int);
    // Compare write on the matching edge must win over the set
    mtc0(CP0_COMPARE, 3'd0, 32'd20);
    mtc0(CP0_COUNT, 3'd0, 32'd20);
    mtc0(CP0_COMPARE, 3'd0, 32'd20);
    exp_push("ti_clear_wins", 32'd0);
    got(bus.timer_int);
    @(negedge clk);
    exp_push("ti_set_after", 32'd1);
    got(bus.timer_int);
`else
    mtc0(CP0_COUNT, 3'd0, 32'd5);
    rd_chk("count_absent", CP0_COUNT, 3'd0, 32'd0);
    mtc0(CP0_COMPARE, 3'd0, 32'd5);
    rd_chk("compare_absent", CP0_COMPARE, 3'd0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen = seen | bus.timer_int;
    end
    exp_push("ti_absent", 32'd0);
    got(seen);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
